// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider:
// default width, FSM state encoding and step-counter sizing.
package seq_restoring_divider_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Enough bits to count 0..w.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/seq_restoring_divider_addsub_step.sv
// Combinational add/subtract step shared with the adder unit.
// en=1 subtracts: b is inverted and en is the carry-in.
module addsub_step #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         en,
    output logic [W-1:0] s,
    output logic         cout
);

    // Single W+1 bit add; the top bit is carry-out (no-borrow when subtracting).
    assign {cout, s} = {1'b0, a}
                     + {1'b0, b ^ {W{en}}}
                     + {{W{1'b0}}, en};

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one shift/trial-subtract
// step per clock; divide-by-zero short-circuits straight to FINISH.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH:0]   r_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   t;
    logic             no_borrow;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;

    addsub_step #(
        .W (WIDTH + 1)
    ) u_step (
        .a    (r_sh),
        .b    ({1'b0, divisor_q}),
        .en   (1'b1),
        .s    (t),
        .cout (no_borrow)
    );

    // One restoring step: shift {R,Q} left, keep the trial difference if it did not borrow.
    always_comb begin
        r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        r_d  = no_borrow ? t : r_sh;
        q_d  = {q_q[WIDTH-2:0], no_borrow};
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            divisor_q <= '0;
            q_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            quot_q  <= '1;
                            rem_q   <= dividend;
                        end else begin
                            state_q   <= ST_CALC;
                            dbz_q     <= 1'b0;
                            q_q       <= dividend;
                            divisor_q <= divisor;
                            r_q       <= '0;
                            cnt_q     <= '0;
                        end
                    end
                end
                ST_CALC: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                        quot_q  <= q_d;
                        rem_q   <= r_d[WIDTH-1:0];
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: cycle model
// built on plain / and %, directed vectors and an exhaustive sweep.
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (dbz)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: cycles remaining in the current operation, results from / and %.
    int           left = 0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic         m_dbz = 1'b0;
    logic [W-1:0] p_q = '0;
    logic [W-1:0] p_r = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left  <= 0;
            m_q   <= '0;
            m_r   <= '0;
            m_dbz <= 1'b0;
        end else if (left == 0) begin
            if (start) begin
                if (divisor == '0) begin
                    left  <= 1;
                    m_q   <= '1;
                    m_r   <= dividend;
                    m_dbz <= 1'b1;
                end else begin
                    left  <= W + 1;
                    m_dbz <= 1'b0;
                    p_q   <= dividend / divisor;
                    p_r   <= dividend % divisor;
                end
            end
        end else begin
            left <= left - 1;
            if (left == 2) begin
                m_q <= p_q;
                m_r <= p_r;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc_busy", {31'd0, busy}, {31'd0, left != 0});
        chk("cyc_done", {31'd0, done}, {31'd0, left == 1});
        chk("cyc_dbz", {31'd0, dbz}, {31'd0, m_dbz});
        if (left <= 1) begin
            chk("cyc_quot", 32'(quotient), 32'(m_q));
            chk("cyc_rem", 32'(remainder), 32'(m_r));
        end
    end

    task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input int eq, input int er, input int edbz,
                      input int elat);
        int lat;
        int bc;
        lat = 0;
        bc  = 0;
        pulse(a, b);
        for (int k = 1; k <= 20; k++) begin
            if (busy) bc++;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk("latency", lat, elat);
        chk("busy_cycles", bc, elat);
        chk("quotient", 32'(quotient), eq);
        chk("remainder", 32'(remainder), er);
        chk("div_by_zero", {31'd0, dbz}, edbz);
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 0);
    endtask

    task automatic sweep_one(input logic [W-1:0] a, input logic [W-1:0] b);
        int seen;
        seen = 0;
        pulse(a, b);
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("sweep_done_seen", seen, 1);
        if (!dbz) begin
            chk("invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            chk("rem_lt_div", {31'd0, remainder < b}, 1);
        end else begin
            chk("sweep_dbz_div", 32'(b), 0);
        end
    endtask

    initial begin
        int nd;
        logic [W-1:0] gq;
        logic [W-1:0] gr;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_quot", 32'(quotient), 0);
        chk("rst_rem", 32'(remainder), 0);
        chk("rst_dbz", {31'd0, dbz}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op(4'd8, 4'd1, 8, 0, 0, 5);
        op(4'd13, 4'd3, 4, 1, 0, 5);
        op(4'd6, 4'd0, 15, 6, 1, 1);
        op(4'd3, 4'd12, 0, 3, 0, 5);
        op(4'd15, 4'd15, 1, 0, 0, 5);
        op(4'd15, 4'd1, 15, 0, 0, 5);

        // Start while busy is ignored.
        nd = 0;
        gq = '0;
        gr = '0;
        pulse(4'd9, 4'd2);
        pulse(4'd7, 4'd7);
        for (int k = 0; k < 10; k++) begin
            if (done) begin
                nd++;
                gq = quotient;
                gr = remainder;
            end
            @(negedge clk);
        end
        chk("ignored_start_dones", nd, 1);
        chk("ignored_start_quot", 32'(gq), 4);
        chk("ignored_start_rem", 32'(gr), 1);
        op(4'd7, 4'd7, 1, 0, 0, 5);

        // Reset in the third CALC cycle.
        pulse(4'd10, 4'd3);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_quot", 32'(quotient), 0);
        chk("abort_rem", 32'(remainder), 0);
        chk("abort_dbz", {31'd0, dbz}, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 0);
        end
        rst_n = 1'b1;
        op(4'd10, 4'd3, 3, 1, 0, 5);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                sweep_one(W'(a), W'(b));
            end
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
